truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper.sv | 154 +++++++++++++++
 tb/tb_truth_table_sweeper.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive input sweeper that compares DUT outputs against expected values
module truth_table_sweeper #(
  parameter int N_IN       = 5,
  parameter int N_OUT      = 3,
  parameter int SETTLE_CYC = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               step_mode,
  input  logic               step,
  input  logic [N_OUT-1:0]   dut_out,
  input  logic [N_OUT-1:0]   exp_out,
  output logic [N_IN-1:0]    stim,
  output logic               busy,
  output logic               done,
  output logic [N_IN:0]      mismatch_cnt,
  output logic [N_IN-1:0]    first_fail,
  output logic               fail_seen,
  output logic [15:0]        signature
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    HOLD,
    DONE
  } state_t;

  localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYC);
  localparam logic [N_IN:0] CNT_MAX   = {1'b1, {N_IN{1'b0}}};

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  settle_cnt;
  logic        begin_sweep;
  logic        advance;
  logic        commit;
  logic        last_vec;
  logic        vec_fail;
  logic [15:0] dut_ext;

  assign last_vec = &stim;
  assign vec_fail = (dut_out != exp_out);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_comb begin
    dut_ext              = '0;
    dut_ext[N_OUT-1:0]   = dut_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // abort is tested first in every active state so it beats step and the SAMPLE commit
  always_comb begin
    state_nxt   = state;
    begin_sweep = 1'b0;
    advance     = 1'b0;
    commit      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          begin_sweep = 1'b1;
          state_nxt   = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (settle_cnt <= 8'd1) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          commit = 1'b1;
          if (last_vec) begin
            state_nxt = DONE;
          end else if (!step_mode) begin
            advance   = 1'b1;
            state_nxt = SETTLE;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (step) begin
          advance   = 1'b1;
          state_nxt = SETTLE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stim         <= '0;
      settle_cnt   <= '0;
      mismatch_cnt <= '0;
      first_fail   <= '0;
      fail_seen    <= 1'b0;
      signature    <= 16'hFFFF;
    end else begin
      if (begin_sweep) begin
        stim         <= '0;
        settle_cnt   <= SETTLE_LOAD;
        mismatch_cnt <= '0;
        first_fail   <= '0;
        fail_seen    <= 1'b0;
        signature    <= 16'hFFFF;
      end
      if (state == SETTLE) begin
        settle_cnt <= settle_cnt - 8'd1;
      end
      if (advance) begin
        stim       <= stim + 1'b1;
        settle_cnt <= SETTLE_LOAD;
      end
      if (commit) begin
        signature <= {signature[14:0], signature[15]} ^ dut_ext;
        if (vec_fail) begin
          if (mismatch_cnt != CNT_MAX) begin
            mismatch_cnt <= mismatch_cnt + 1'b1;
          end
          if (!fail_seen) begin
            first_fail <= stim;
            fail_seen  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - randomized self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;
  localparam int N_IN       = 5;
  localparam int N_OUT      = 3;
  localparam int SETTLE_CYC = 1;
  localparam int NV         = 1 << N_IN;
  localparam int SWEEP_LAT  = 1 + NV * (SETTLE_CYC + 1);
  localparam int BUDGET     = 2000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic             step_mode;
  logic             step;
  logic [N_OUT-1:0] dut_out;
  logic [N_OUT-1:0] exp_out;
  logic [N_IN-1:0]  stim;
  logic             busy;
  logic             done;
  logic [N_IN:0]    mismatch_cnt;
  logic [N_IN-1:0]  first_fail;
  logic             fail_seen;
  logic [15:0]      signature;

  logic [N_OUT-1:0] dut_tab [NV];
  logic [N_OUT-1:0] exp_tab [NV];

  int n_checks = 0;
  int n_fail   = 0;

  truth_table_sweeper #(
    .N_IN(N_IN),
    .N_OUT(N_OUT),
    .SETTLE_CYC(SETTLE_CYC)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .step_mode(step_mode),
    .step(step),
    .dut_out(dut_out),
    .exp_out(exp_out),
    .stim(stim),
    .busy(busy),
    .done(done),
    .mismatch_cnt(mismatch_cnt),
    .first_fail(first_fail),
    .fail_seen(fail_seen),
    .signature(signature)
  );

  always #5 clk = ~clk;

  // the device under test is modelled as a lookup table addressed by the current vector
  assign dut_out = dut_tab[stim];
  assign exp_out = exp_tab[stim];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode: 0 match, 1 fail at 13/30, 2 all-zero, 3 one at stim 0, 4 random fails, 5 all fail
  task automatic fill(input int mode);
    for (int v = 0; v < NV; v++) begin
      dut_tab[v] = N_OUT'($urandom);
      if (mode == 2 || mode == 3) dut_tab[v] = '0;
      if (mode == 3 && v == 0) dut_tab[v] = 1;
      exp_tab[v] = dut_tab[v];
      if ((mode == 1 && (v == 13 || v == 30)) || mode == 5 ||
          (mode == 4 && $urandom_range(0, 3) == 0))
        exp_tab[v] = dut_tab[v] ^ N_OUT'($urandom_range(1, (1 << N_OUT) - 1));
    end
  endtask

  task automatic model(input int upto, output int cnt, output int ff, output int fs,
                       output logic [15:0] sig);
    cnt = 0; ff = 0; fs = 0; sig = 16'hFFFF;
    for (int v = 0; v < upto; v++) begin
      if (dut_tab[v] != exp_tab[v]) begin
        if (fs == 0) ff = v;
        fs = 1;
        cnt++;
      end
      sig = {sig[14:0], sig[15]} ^ 16'(dut_tab[v]);
    end
  endtask

  task automatic check_results(input string pfx, input int upto);
    int cnt, ff, fs;
    logic [15:0] sig;
    model(upto, cnt, ff, fs, sig);
    check({pfx, "_cnt"}, 32'(mismatch_cnt), cnt);
    check({pfx, "_first_fail"}, 32'(first_fail), ff);
    check({pfx, "_fail_seen"}, 32'(fail_seen), fs);
    check({pfx, "_signature"}, 32'(signature), 32'(sig));
  endtask

  task automatic run_sweep(input string pfx);
    int lat, stim_err;
    start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    stim_err = 0;
    while (!done && lat < BUDGET) begin
      if (int'(stim) != (lat - 1) / (SETTLE_CYC + 1)) stim_err++;
      tick;
      lat++;
    end
    check({pfx, "_latency"}, lat, SWEEP_LAT);
    check({pfx, "_stim_walk"}, stim_err, 0);
    check({pfx, "_busy_in_done"}, 32'(busy), 1);
    check_results(pfx, NV);
    tick;
    check({pfx, "_done_pulse"}, 32'(done), 0);
    check({pfx, "_busy_after"}, 32'(busy), 0);
  endtask

  task automatic wait_stim(input int vec, input string pfx);
    int n = 0;
    while (int'(stim) != vec && n < BUDGET) begin
      tick;
      n++;
    end
    check({pfx, "_reached"}, 32'(n < BUDGET), 1);
  endtask

  task automatic abort_at(input int vec, input bit in_sample, input string pfx);
    int pulses = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_stim(vec, pfx);
    if (in_sample) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check({pfx, "_busy"}, 32'(busy), 0);
    check_results(pfx, vec);
    repeat (6) begin
      pulses += int'(done);
      tick;
    end
    check({pfx, "_no_done"}, pulses, 0);
  endtask

  initial begin
    int seq_err, busy_low;
    rst = 1'b1; start = 1'b0; abort = 1'b0; step_mode = 1'b0; step = 1'b0;
    fill(0);
    tick;
    tick;
    rst = 1'b0;
    check("rst_stim", 32'(stim), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cnt", 32'(mismatch_cnt), 0);
    check("rst_first_fail", 32'(first_fail), 0);
    check("rst_fail_seen", 32'(fail_seen), 0);
    check("rst_signature", 32'(signature), 32'hFFFF);

    run_sweep("match");
    check("match_cnt_zero", 32'(mismatch_cnt), 0);

    fill(1);
    run_sweep("two_fail");
    check("two_fail_cnt2", 32'(mismatch_cnt), 2);
    check("two_fail_first13", 32'(first_fail), 32'b01101);

    fill(2);
    run_sweep("zeros");
    check("zeros_sig_ffff", 32'(signature), 32'hFFFF);

    fill(3);
    run_sweep("onehot");
    check("onehot_sig_differs", 32'(signature != 16'hFFFF), 1);

    fill(5);
    run_sweep("all_fail");
    check("all_fail_cnt_max", 32'(mismatch_cnt), NV);

    for (int r = 0; r < 4; r++) begin
      fill(4);
      run_sweep($sformatf("rand%0d", r));
    end

    fill(4);
    step_mode = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    seq_err = 0;
    busy_low = 0;
    for (int v = 1; v <= 3; v++) begin
      repeat (3) begin
        start = 1'b1;
        tick;
        start = 1'b0;
        if (int'(stim) != v - 1) seq_err++;
        if (!busy) busy_low++;
      end
      step = 1'b1;
      tick;
      step = 1'b0;
      if (int'(stim) != v) seq_err++;
      tick;
      tick;
      if (!busy) busy_low++;
    end
    check("step_seq", seq_err, 0);
    check("step_busy", busy_low, 0);
    check("step_stim3", 32'(stim), 3);
    check_results("step_partial", 4);
    step_mode = 1'b0;
    step = 1'b1;
    tick;
    step = 1'b0;
    wait_stim(NV - 1, "step_to_free");
    tick;
    tick;
    check("step_free_done", 32'(done), 1);
    check_results("step_free", NV);
    tick;

    fill(4);
    abort_at(10, 1'b0, "abort_settle");
    fill(5);
    abort_at(10, 1'b1, "abort_sample");
    fill(0);
    run_sweep("after_abort");

    fill(5);
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_stim(20, "rst_mid");
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rst_mid_stim", 32'(stim), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", 32'(done), 0);
    check("rst_mid_cnt", 32'(mismatch_cnt), 0);
    check("rst_mid_first_fail", 32'(first_fail), 0);
    check("rst_mid_fail_seen", 32'(fail_seen), 0);
    check("rst_mid_signature", 32'(signature), 32'hFFFF);
    run_sweep("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
